// File: rtl/if_fetch_queue.sv
// Instruction-fetch PC generator with a DEPTH-entry fetch queue feeding ID; optional bypass via IF_FETCH_QUEUE_BYPASS_EN.
// Latency: imem_req to out_valid is 2 cycles (1 cycle with IF_FETCH_QUEUE_BYPASS_EN when the queue is empty).
// Backpressure: id_ready=0 lets the queue fill; credit (out_count + inflight < DEPTH) stops issue so nothing overflows.
module if_fetch_queue #(
    parameter int unsigned          ADDR_W   = 32,
    parameter int unsigned          INSTR_W  = 32,
    parameter int unsigned          DEPTH    = 4,
    parameter logic [ADDR_W-1:0]    RESET_PC = '0,
    parameter int unsigned          PC_INC   = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    output logic                        imem_req,
    output logic [ADDR_W-1:0]           imem_addr,
    input  logic [INSTR_W-1:0]          imem_rdata,
    input  logic                        redirect,
    input  logic [ADDR_W-1:0]           redirect_addr,
    input  logic                        flush,
    input  logic                        pc_write,
    input  logic                        id_ready,
    output logic                        out_valid,
    output logic [ADDR_W-1:0]           out_next_pc,
    output logic [INSTR_W-1:0]          out_instr,
    output logic [$clog2(DEPTH):0]      out_count
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  fetch_addr;
    logic               inflight;
    logic [INSTR_W-1:0] instr_mem [DEPTH];
    logic [ADDR_W-1:0]  npc_mem   [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;

    logic               kill;
    logic               rsp_vld;
    logic [ADDR_W-1:0]  rsp_npc;
    logic [CNT_W-1:0]   used;
    logic               empty;
    logic               enq;
    logic               pop;

    assign kill      = redirect | flush;
    // A response landing in a redirect/flush cycle belongs to the squashed path.
    assign rsp_vld   = inflight & ~kill;
    assign rsp_npc   = fetch_addr + ADDR_W'(PC_INC);
    assign used      = count + CNT_W'(inflight);
    assign empty     = (count == '0);
    assign imem_req  = rst & pc_write & ~kill & (used < CNT_W'(DEPTH));
    assign imem_addr = pc;
    assign out_count = count;
    assign pop       = ~empty & id_ready;

`ifdef IF_FETCH_QUEUE_BYPASS_EN
    logic byp;
    assign byp         = empty & rsp_vld;
    assign out_valid   = ~empty | byp;
    assign out_instr   = empty ? imem_rdata : instr_mem[rd_ptr];
    assign out_next_pc = empty ? rsp_npc    : npc_mem[rd_ptr];
    // A bypassed word consumed by ID this cycle never occupies a slot.
    assign enq         = rsp_vld & ~(byp & id_ready);
`else
    assign out_valid   = ~empty;
    assign out_instr   = instr_mem[rd_ptr];
    assign out_next_pc = npc_mem[rd_ptr];
    assign enq         = rsp_vld;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc         <= RESET_PC;
            fetch_addr <= RESET_PC;
            inflight   <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
        end else begin
            if (redirect) begin
                pc <= redirect_addr;
            end else if (imem_req) begin
                pc <= pc + ADDR_W'(PC_INC);
            end
            inflight <= imem_req;
            if (imem_req) begin
                fetch_addr <= pc;
            end
            if (kill) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (enq) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                count <= count + CNT_W'(enq) - CNT_W'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            instr_mem[wr_ptr] <= imem_rdata;
            npc_mem[wr_ptr]   <= rsp_npc;
        end
    end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue: memory model answers one cycle after each request, scoreboard checks ID deliveries.
module tb_if_fetch_queue;
    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_addr;
    logic        flush;
    logic        pc_write;
    logic        id_ready;
    logic        out_valid;
    logic [31:0] out_next_pc;
    logic [31:0] out_instr;
    logic [2:0]  out_count;

    if_fetch_queue dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .flush         (flush),
        .pc_write      (pc_write),
        .id_ready      (id_ready),
        .out_valid     (out_valid),
        .out_next_pc   (out_next_pc),
        .out_instr     (out_instr),
        .out_count     (out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] npc;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hC0DE_0000 ^ {a[15:0], a[31:16]};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] a);
        exp_t e;
        e.instr = mem_word(a);
        e.npc   = a + 32'd4;
        sb_q.push_back(e);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Instruction memory: answers the request seen in one cycle during the next.
    logic        resp_vld = 1'b0;
    initial begin
        logic        nxt_vld;
        logic [31:0] nxt_addr;
        imem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (rst && resp_vld && !redirect && !flush &&
                out_count == 3'(DEPTH) && !(out_valid && id_ready)) begin
                n_chk++;
                n_fail++;
                $display("FAIL enqueue_while_full: count %0d with response arriving", out_count);
            end
            nxt_vld  = imem_req;
            nxt_addr = imem_addr;
            @(posedge clk);
            #1;
            resp_vld   = nxt_vld;
            imem_rdata = nxt_vld ? mem_word(nxt_addr) : 32'hDEAD_BEEF;
        end
    end

    // Delivery monitor.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst && out_valid && id_ready) begin
                if (sb_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_delivery: instr %0h npc %0h, expected none", out_instr, out_next_pc);
                end else begin
                    e = sb_q.pop_front();
                    chk("deliver_instr", 64'(out_instr), 64'(e.instr));
                    chk("deliver_npc", 64'(out_next_pc), 64'(e.npc));
                end
            end
        end
    end

    task automatic do_reset(input logic rdy);
        cyc();
        chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        rst       = 1'b0;
        id_ready  = rdy;
        redirect  = 1'b0;
        flush     = 1'b0;
        pc_write  = 1'b1;
        @(negedge clk);
        chk("rst_imem_req", 64'(imem_req), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_count", 64'(out_count), 64'd0);
        chk("rst_imem_addr", 64'(imem_addr), 64'd0);
        cyc();
        rst = 1'b1;
    endtask

    initial begin
        rst           = 1'b0;
        redirect      = 1'b0;
        redirect_addr = 32'h0;
        flush         = 1'b0;
        pc_write      = 1'b1;
        id_ready      = 1'b1;

        // Sequential fetch from reset, ID always ready.
        do_reset(1'b1);
        push_exp(32'h0); push_exp(32'h4); push_exp(32'h8); push_exp(32'hC);
        @(negedge clk);
        chk("t1_c0_req", 64'(imem_req), 64'd1);
        chk("t1_c0_addr", 64'(imem_addr), 64'h0);
        cyc(); @(negedge clk);
        chk("t1_c1_addr", 64'(imem_addr), 64'h4);
        chk("t1_c1_valid", 64'(out_valid), 64'd0);
        cyc(); @(negedge clk);
        chk("t1_c2_addr", 64'(imem_addr), 64'h8);
        chk("t1_c2_valid", 64'(out_valid), 64'd1);
        chk("t1_c2_instr", 64'(out_instr), 64'(mem_word(32'h0)));
        chk("t1_c2_npc", 64'(out_next_pc), 64'h4);
        for (int i = 3; i <= 5; i++) begin
            cyc(); @(negedge clk);
        end

        // ID stalled: queue fills to DEPTH and issue stops at PC 16.
        do_reset(1'b0);
        push_exp(32'h0); push_exp(32'h4); push_exp(32'h8); push_exp(32'hC); push_exp(32'h10);
        @(negedge clk);
        for (int i = 1; i <= 9; i++) begin
            cyc(); @(negedge clk);
        end
        chk("t2_full_count", 64'(out_count), 64'd4);
        chk("t2_full_req", 64'(imem_req), 64'd0);
        chk("t2_full_addr", 64'(imem_addr), 64'h10);
        chk("t2_head_instr", 64'(out_instr), 64'(mem_word(32'h0)));
        cyc(); id_ready = 1'b1; @(negedge clk);
        chk("t2_c10_req", 64'(imem_req), 64'd0);
        for (int i = 11; i <= 14; i++) begin
            cyc(); @(negedge clk);
        end

        // Redirect with 3 queued and 1 in flight.
        do_reset(1'b0);
        push_exp(32'h100); push_exp(32'h104); push_exp(32'h108);
        @(negedge clk);
        for (int i = 1; i <= 3; i++) begin
            cyc(); @(negedge clk);
        end
        cyc(); redirect = 1'b1; redirect_addr = 32'h100; @(negedge clk);
        chk("t3_pre_count", 64'(out_count), 64'd3);
        chk("t3_redir_req", 64'(imem_req), 64'd0);
        cyc(); redirect = 1'b0; id_ready = 1'b1; @(negedge clk);
        chk("t3_count_cleared", 64'(out_count), 64'd0);
        chk("t3_addr_target", 64'(imem_addr), 64'h100);
        chk("t3_valid_cleared", 64'(out_valid), 64'd0);
        cyc(); @(negedge clk);
        chk("t3_no_stale", 64'(out_valid), 64'd0);
        for (int i = 7; i <= 9; i++) begin
            cyc(); @(negedge clk);
        end

        // Flush at PC 0x20 while the head is being consumed.
        do_reset(1'b1);
        for (int a = 0; a <= 'h18; a += 4) push_exp(32'(a));
        push_exp(32'h20); push_exp(32'h24);
        @(negedge clk);
        for (int i = 1; i <= 7; i++) begin
            cyc(); @(negedge clk);
        end
        cyc(); flush = 1'b1; @(negedge clk);
        chk("t4_flush_pc", 64'(imem_addr), 64'h20);
        chk("t4_flush_req", 64'(imem_req), 64'd0);
        chk("t4_flush_deq_valid", 64'(out_valid), 64'd1);
        cyc(); flush = 1'b0; @(negedge clk);
        chk("t4_count_cleared", 64'(out_count), 64'd0);
        chk("t4_addr_kept", 64'(imem_addr), 64'h20);
        chk("t4_req_resume", 64'(imem_req), 64'd1);
        cyc(); @(negedge clk);
        chk("t4_no_stale", 64'(out_valid), 64'd0);
        for (int i = 11; i <= 12; i++) begin
            cyc(); @(negedge clk);
        end

        // PC wrap at the top of the address space.
        do_reset(1'b1);
        redirect = 1'b1; redirect_addr = 32'hFFFF_FFF8;
        push_exp(32'hFFFF_FFF8); push_exp(32'hFFFF_FFFC); push_exp(32'h0);
        @(negedge clk);
        chk("t5_redir_req", 64'(imem_req), 64'd0);
        cyc(); redirect = 1'b0; @(negedge clk);
        chk("t5_addr_fff8", 64'(imem_addr), 64'hFFFF_FFF8);
        cyc(); @(negedge clk);
        chk("t5_addr_fffc", 64'(imem_addr), 64'hFFFF_FFFC);
        cyc(); @(negedge clk);
        chk("t5_addr_wrap", 64'(imem_addr), 64'h0);
        cyc(); @(negedge clk);
        chk("t5_npc_wrap", 64'(out_next_pc), 64'h0);
        cyc(); @(negedge clk);

`ifdef IF_FETCH_QUEUE_BYPASS_EN
        // Bypass: word goes straight to ID one cycle after the request.
        do_reset(1'b1);
        push_exp(32'h0); push_exp(32'h4);
        @(negedge clk);
        chk("t6_req", 64'(imem_req), 64'd1);
        cyc(); @(negedge clk);
        chk("t6_byp_valid", 64'(out_valid), 64'd1);
        chk("t6_byp_count", 64'(out_count), 64'd0);
        cyc(); @(negedge clk);
        chk("t6_byp_count2", 64'(out_count), 64'd0);
`endif

        cyc();
        chk("final_scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
